fan_psum_collector: RTL

//  Downstream of the FAN adder stage. Consumes the two (valid, data, row) output lanes of the

---
 rtl/fan_psum_collector.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fan_psum_collector.sv
`default_nettype none
// ============================================================================
// Module      : fan_psum_collector
// Description : Partial-sum collector placed after the FAN adder stage.
//               Two (valid, data, row) lanes accumulate into NUM_ROWS
//               accumulator rows. When a tile ends (in_last), every row is
//               drained in order over a valid/ready stream and cleared as it
//               goes. Input is stalled for the whole drain.
// Ports       :
//   clk        in   1            rising-edge clock
//   rst_n      in   1            synchronous reset, active low
//   in_valid   in   2            per-lane valid
//   in_data    in   2*DW_DATA    lane i data at [i*DW_DATA +: DW_DATA]
//   in_row     in   2*ROW_W      lane i row  at [i*ROW_W +: ROW_W]
//   in_last    in   1            tile end; same-cycle lane data included
//   in_ready   out  1            inputs accepted this cycle
//   out_valid  out  1            drain beat valid
//   out_data   out  DW_DATA      accumulated sum of out_row
//   out_row    out  ROW_W        row index of current beat
//   out_last   out  1            beat for row NUM_ROWS-1
//   out_ready  in   1            downstream accepts beat
//   err        out  1            sticky out-of-range row flag
// Revision    : 1.0 - initial release
// ============================================================================
module fan_psum_collector #(
  parameter int DW_DATA  = 32,
  parameter int NUM_ROWS = 16,
  parameter int ROW_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           in_valid,
  input  logic [2*DW_DATA-1:0] in_data,
  input  logic [2*ROW_W-1:0]   in_row,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DW_DATA-1:0]   out_data,
  output logic [ROW_W-1:0]     out_row,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 err
);

  // One extra bit so NUM_ROWS == 2**ROW_W still compares correctly.
  localparam logic [ROW_W:0]   c_num_rows = (ROW_W+1)'(NUM_ROWS);
  localparam logic [ROW_W-1:0] c_last_row = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  // Becomes 1 only once rst_n has been sampled high at an edge.
  logic               rdy_q, rdy_d;
  logic [DW_DATA-1:0] acc_q [NUM_ROWS];
  logic [DW_DATA-1:0] acc_d [NUM_ROWS];

  logic [DW_DATA-1:0] lane_data [2];
  logic [ROW_W-1:0]   lane_row  [2];
  logic [1:0]         lane_ok;
  logic [1:0]         lane_bad;
  logic               beat;
  logic [DW_DATA-1:0] sel_acc;

  // Handshake-level outputs are gated by rst_n so they drop in the very
  // cycle reset is asserted, not one edge later.
  assign in_ready  = rst_n & rdy_q & (state_q == ST_ACCUM);
  assign out_valid = rst_n & (state_q == ST_DRAIN);
  assign beat      = out_valid & out_ready;

  // Lane unpacking and range classification.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lane_data[i] = in_data[i*DW_DATA +: DW_DATA];
      lane_row[i]  = in_row[i*ROW_W +: ROW_W];
      lane_ok[i]   = in_ready & in_valid[i] & ({1'b0, lane_row[i]} <  c_num_rows);
      lane_bad[i]  = in_ready & in_valid[i] & ({1'b0, lane_row[i]} >= c_num_rows);
    end
  end

  // Mux of the row currently being drained; a loop avoids indexing the
  // array with a wider-than-needed index.
  always_comb begin
    sel_acc = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (idx_q == ROW_W'(r)) begin
        sel_acc = acc_q[r];
      end
    end
  end

  assign out_data = out_valid ? sel_acc : '0;
  assign out_row  = out_valid ? idx_q : '0;
  assign out_last = out_valid & (idx_q == c_last_row);
  assign err      = err_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rdy_d   = 1'b1;
    err_d   = err_q | lane_bad[0] | lane_bad[1];

    // Both lanes may hit the same row; the two addends fold into one
    // update so neither contribution is lost. Sums wrap naturally.
    for (int r = 0; r < NUM_ROWS; r++) begin
      acc_d[r] = acc_q[r]
               + ((lane_ok[0] && lane_row[0] == ROW_W'(r)) ? lane_data[0] : '0)
               + ((lane_ok[1] && lane_row[1] == ROW_W'(r)) ? lane_data[1] : '0);
      if (beat && idx_q == ROW_W'(r)) begin
        acc_d[r] = '0;
      end
    end

    case (state_q)
      ST_ACCUM: begin
        if (in_ready && in_last) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (beat) begin
          if (idx_q == c_last_row) begin
            idx_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_ACCUM;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        acc_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      acc_q   <= acc_d;
    end
  end

endmodule
`default_nettype wire
